// File: rtl/nexys_starship_shooter.sv
// nexys_starship_shooter
// Shooter controller for the Nexys starship game. The player aims in one of
// four directions and fires; after FLIGHT_TICKS game ticks the shot arrives
// and destroys the monster in the target direction if one is present at that
// moment. A cooldown of COOL_TICKS game ticks follows before the player may
// aim and fire again.
//
// Monster flags pass straight through from monster_sm to monster_ctrl. The
// only change is a one-cycle registered kill mask that clears the flag of a
// monster that has just been hit.
//
// There are no valid/ready handshakes in this block. Every control input is
// a single-cycle pulse that is acted on in the cycle it is high. No pulse is
// queued or stretched, so a button pulse that arrives in a state where it is
// ignored is lost.
//
// The FSM state is visible on the one-hot outputs q_Sh_Init/Aim/Shot/Cool.

module nexys_starship_shooter #(
   parameter int FLIGHT_TICKS = 3,
   parameter int COOL_TICKS   = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       timer_tick,
   input  logic       play_flag,
   input  logic       gameover_ctrl,
   input  logic       BtnU,
   input  logic       BtnD,
   input  logic       BtnL,
   input  logic       BtnR,
   input  logic       BtnC,
   input  logic [3:0] monster_sm,
   output logic [3:0] monster_ctrl,
   output logic [1:0] aim_dir,
   output logic       shot_active,
   output logic [7:0] hit_count,
   output logic       q_Sh_Init,
   output logic       q_Sh_Aim,
   output logic       q_Sh_Shot,
   output logic       q_Sh_Cool
);

   // One-hot state encoding. Any other value is illegal and recovers to INIT.
   typedef enum logic [3:0] {
      INIT = 4'b0001,
      AIM  = 4'b0010,
      SHOT = 4'b0100,
      COOL = 4'b1000
   } state_t;

   // Direction codes. They double as bit indices into the monster flag vectors.
   localparam logic [1:0] DIR_TOP    = 2'd3;
   localparam logic [1:0] DIR_BOTTOM = 2'd2;
   localparam logic [1:0] DIR_LEFT   = 2'd1;
   localparam logic [1:0] DIR_RIGHT  = 2'd0;

   // Terminal counts for the 4-bit tick counters (legal range 1-15).
   localparam logic [3:0] FLIGHT_LAST = 4'(FLIGHT_TICKS);
   localparam logic [3:0] COOL_LAST   = 4'(COOL_TICKS);

   state_t      state;
   logic [1:0]  target;
   logic [3:0]  flight_cnt;
   logic [3:0]  cool_cnt;
   logic [3:0]  kill_mask;

   logic [3:0]  flight_next;
   logic [3:0]  cool_next;
   logic        arrival;
   logic        cool_done;
   logic        target_present;
   logic [3:0]  kill_onehot;
   logic        dir_valid;
   logic [1:0]  dir_next;
   logic [7:0]  hit_next;

   // Decode the aim buttons. Simultaneous presses resolve U > D > L > R.
   always_comb begin
      dir_valid = 1'b1;
      dir_next  = aim_dir;
      if (BtnU) begin
         dir_next = DIR_TOP;
      end else if (BtnD) begin
         dir_next = DIR_BOTTOM;
      end else if (BtnL) begin
         dir_next = DIR_LEFT;
      end else if (BtnR) begin
         dir_next = DIR_RIGHT;
      end else begin
         dir_valid = 1'b0;
      end
   end

   // Work out when the shot lands, whether it hits, and when cooldown ends.
   always_comb begin
      flight_next    = flight_cnt + 4'd1;
      cool_next      = cool_cnt + 4'd1;
      arrival        = (state == SHOT) && timer_tick && (flight_next == FLIGHT_LAST);
      cool_done      = (state == COOL) && timer_tick && (cool_next == COOL_LAST);
      target_present = monster_sm[target];
      kill_onehot    = 4'b0001 << target;
      hit_next       = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
   end

   // Main controller: state, aim, target, counters, kill mask and hit count.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= INIT;
         aim_dir    <= DIR_TOP;
         target     <= DIR_TOP;
         hit_count  <= 8'd0;
         kill_mask  <= 4'd0;
         flight_cnt <= 4'd0;
         cool_cnt   <= 4'd0;
      end else begin
         // The kill mask lasts for exactly one cycle after a hitting arrival.
         kill_mask <= 4'd0;
         if (gameover_ctrl) begin
            // Game over overrides everything else. A shot still in flight
            // is dropped without scoring.
            state <= INIT;
         end else begin
            case (state)
               INIT: begin
                  if (play_flag) begin
                     state <= AIM;
                  end
               end
               AIM: begin
                  if (BtnC) begin
                     // Fire takes precedence. Any direction pulse in the
                     // same cycle is dropped, so the shot uses the current aim.
                     state      <= SHOT;
                     target     <= aim_dir;
                     flight_cnt <= 4'd0;
                  end else if (dir_valid) begin
                     aim_dir <= dir_next;
                  end
               end
               SHOT: begin
                  if (timer_tick) begin
                     flight_cnt <= flight_next;
                  end
                  if (arrival) begin
                     // Only the monster flag sampled on the arrival cycle matters.
                     if (target_present) begin
                        kill_mask <= kill_onehot;
                        hit_count <= hit_next;
                     end
                     state    <= COOL;
                     cool_cnt <= 4'd0;
                  end
               end
               COOL: begin
                  if (timer_tick) begin
                     cool_cnt <= cool_next;
                  end
                  if (cool_done) begin
                     state <= AIM;
                  end
               end
               default: begin
                  state <= INIT;
               end
            endcase
         end
      end
   end

   // Monster flags are echoed back combinationally. The only masking applied
   // is the one-cycle kill.
   assign monster_ctrl = monster_sm & ~kill_mask;

   assign q_Sh_Init   = (state == INIT);
   assign q_Sh_Aim    = (state == AIM);
   assign q_Sh_Shot   = (state == SHOT);
   assign q_Sh_Cool   = (state == COOL);
   assign shot_active = q_Sh_Shot;

endmodule

// File: doc/nexys_starship_shooter.md
NEXYS_STARSHIP_SHOOTER -- requirements
Module: nexys_starship_shooter

Interface
REQ-001 Parameter FLIGHT_TICKS, default 3: timer_tick pulses from fire to shot arrival; legal range 1-15.
REQ-002 Parameter COOL_TICKS, default 2: timer_tick pulses of post-shot cooldown before re-arm; legal range 1-15.
REQ-003 Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 timer_tick  input  1  one-Clk-wide game-time enable pulse.
REQ-006 play_flag  input  1  game start request.
REQ-007 gameover_ctrl  input  1  game over; aborts play.
REQ-008 BtnU, BtnD, BtnL, BtnR, BtnC  input  1 each  debounced single-cycle button pulses (aim up/down/left/right, fire).
REQ-009 monster_sm  input  4  monster-present flags [3]=top, [2]=bottom, [1]=left, [0]=right, from the per-direction monster state machines.
REQ-010 monster_ctrl  output  4  returned monster flags, same bit order; consumed by the monster state machines as their next monster_sm value.
REQ-011 aim_dir  output  2  current aim: 3=top, 2=bottom, 1=left, 0=right.
REQ-012 shot_active  output  1  high while a shot is in flight.
REQ-013 hit_count  output  8  saturating count of monsters destroyed.
REQ-014 q_Sh_Init, q_Sh_Aim, q_Sh_Shot, q_Sh_Cool  output  1 each  one-hot state outputs.

Function
REQ-015 States SHALL be INIT, AIM, SHOT, COOL, one-hot encoded; any illegal encoding SHALL return to INIT on the next Clk.
REQ-016 INIT: play_flag=1 -> AIM next Clk; otherwise remain; all buttons ignored.
REQ-017 AIM: BtnC=1 -> SHOT next Clk, flight counter cleared to 0, target latched = aim_dir.
REQ-018 AIM: with BtnC=0, a direction pulse updates aim_dir next Clk; on simultaneous direction pulses, priority is U > D > L > R.
REQ-019 AIM: BtnC and a direction pulse in the same cycle -> fire at the previously latched aim_dir; the direction pulse is discarded.
REQ-020 SHOT: flight counter (4 bits) SHALL increment once per timer_tick; arrival is the Clk on which a timer_tick brings the count to FLIGHT_TICKS.
REQ-021 On arrival, if monster_sm[target]=1 in that cycle, kill_mask[target] SHALL be high for exactly the next Clk cycle and hit_count SHALL increment, saturating at 255.
REQ-022 On arrival with monster_sm[target]=0 (miss), there SHALL be no kill and no count change; a monster that appears or disappears before arrival has no effect.
REQ-023 After arrival (hit or miss) -> COOL next Clk, with the cooldown counter cleared.
REQ-024 COOL: count timer_tick pulses; on reaching COOL_TICKS -> AIM next Clk; all buttons ignored in SHOT and COOL.
REQ-025 monster_ctrl SHALL be combinational: monster_ctrl[d] = monster_sm[d] AND NOT kill_mask[d], with kill_mask registered, so monsters raised by the monster state machines are echoed back with zero latency.
REQ-026 gameover_ctrl=1 in AIM, SHOT or COOL -> INIT next Clk; an in-flight shot is cancelled with no kill, and kill_mask is cleared.
REQ-027 gameover_ctrl takes priority over arrival, fire and play_flag in the same cycle.
REQ-028 shot_active = q_Sh_Shot.
REQ-029 aim_dir and hit_count SHALL hold their values through INIT; they are cleared only by Reset.

Reset
REQ-030 Reset=0 SHALL asynchronously force INIT, aim_dir=3, hit_count=0, kill_mask=0, flight counter=0 and cooldown counter=0; monster_ctrl then equals monster_sm.
REQ-031 Reset asserted mid-shot SHALL cancel the shot with no kill pulse; operation resumes in INIT on the first Clk after Reset returns high.

Verification
REQ-032 Reset, play_flag pulse, BtnL, BtnC, then 3 ticks with monster_sm=4'b0010 -> monster_ctrl[1]=0 for exactly 1 Clk, hit_count=1, COOL, then AIM after 2 further ticks.
REQ-033 Fire at top with monster_sm=0 at arrival -> no kill pulse, hit_count unchanged, COOL then AIM.
REQ-034 BtnU and BtnR in the same cycle -> aim_dir=3; BtnC and BtnD in the same cycle with aim_dir=3 -> shot target is top, aim_dir stays 3.
REQ-035 gameover_ctrl raised on the same Clk as a hitting arrival -> INIT next Clk, no kill pulse, hit_count unchanged.
REQ-036 hit_count preloaded to 255 by 255 hits, then one further hit -> hit_count stays 255 and the kill pulse still occurs.
REQ-037 monster_sm[2] rising in AIM -> monster_ctrl[2]=1 in the same cycle; Reset asserted mid-SHOT -> INIT immediately with kill_mask=0.
